spi_mnrch_cfg: RTL and testbench
================================

// Module: spi_mnrch_cfg
// PURPOSE
//  Parametrised SPI monarch: next generation of the 16-bit inertial-sensor SPI master.
//  Adds configurable word width, SCLK divider, SCLK polarity and bit order.
//  Adds per-transaction length, multiple serf selects, a busy flag and a registered response.
//  Sits between the sensor/command FSMs and the off-chip SPI serfs.
// PARAMETERS
//  DATA_W    16  maximum transaction length in bits (>=2)
//  DIV_W     5   SCLK divider counter width; SCLK period P = 2**DIV_W clk (DIV_W>=3)
//  NUM_SS    1   number of active-low serf selects
//  CPOL      1   SCLK idle level; data launched on leading-from-idle edge, sampled on the other
//  LSB_FIRST 0   0: MSB first on MOSI; 1: LSB first
// PORTS
//  clk     in   1                  system clock
//  rst_n   in   1                  reset, asynchronous, active-low
//  snd     in   1                  1-clk request to start a transaction
//  cmd     in   DATA_W             word to transmit
//  len     in   $clog2(DATA_W+1)   bits to transfer; 0 means DATA_W; values >DATA_W clamp to DATA_W
//  ss_sel  in   max(1,$clog2(NUM_SS))  serf select index
//  MISO    in   1                  serf -> monarch data
//  SCLK    out  1                  serial clock
//  MOSI    out  1                  monarch -> serf data
//  SS_n    out  NUM_SS             active-low serf selects
//  resp    out  DATA_W             received word, right-justified, zero-extended
//  busy    out  1                  high while state != IDLE
//  done    out  1                  set at completion; held until the next accepted snd
// BEHAVIOUR
//  Reset:
//   - SS_n all 1, SCLK=CPOL, MOSI=0, resp=0, busy=0, done=0, state IDLE.
//   - Asynchronous reset mid-transaction aborts immediately; no partial resp update.
//  Divider counter cnt[DIV_W-1:0]:
//   - In IDLE, cnt is held at LOAD = 3*P/4-1 (5'b10111 for DIV_W=5).
//   - cnt increments every clk in XFER and BACK_PORCH; it wraps naturally.
//   - SCLK = cnt[MSB] when CPOL=1, ~cnt[MSB] when CPOL=0.
//   - shft pulse when cnt == P/2+1, in XFER only.
//  States:
//   - IDLE -> XFER on snd with ss_sel<NUM_SS.
//     The same cycle asserts init: shift reg loaded, bit count cleared, done cleared.
//     SS_n[ss_sel] goes 0 on the next clk.
//     snd with ss_sel>=NUM_SS is ignored; state, done and resp are unchanged.
//   - XFER: on each shft, shift reg shifts by one and MISO enters the vacated end; bit count +1.
//     On the shft that completes bit len_eff, go to BACK_PORCH.
//   - BACK_PORCH: when cnt is all ones, set_done fires and state returns to IDLE.
//     On the next clk: done=1, SS_n all 1, resp updated.
//  Load and data alignment:
//   - MSB-first: shift reg loaded with cmd<<(DATA_W-len_eff); MOSI = sreg[DATA_W-1];
//     shift left, MISO enters at bit 0; resp = sreg & mask(len_eff).
//   - LSB-first: shift reg loaded with cmd; MOSI = sreg[0]; shift right, MISO enters at MSB;
//     resp = sreg >> (DATA_W-len_eff).
//  Timing and handshake:
//   - done rises P/4 + 2 + P*len_eff clks after the snd cycle (DIV_W=5, len 16: 522).
//   - Exactly len_eff sampling edges per transaction.
//   - MOSI changes 2 clk after each sampling edge; it is stable across the following sampling edge.
//   - snd while busy is ignored, with no effect on the in-flight transfer.
//   - snd in the same cycle as set_done is ignored; the requester waits for busy=0.
//   - Back-to-back: snd in the first IDLE cycle after done is accepted.
// TESTING
//  1. Reset: assert rst_n=0 -> SS_n all 1, SCLK=CPOL, done=0, busy=0, resp=0.
//  2. Defaults, cmd=16'hA5C3, len=0, serf returns 16'h3C5A:
//     -> 16 rising SCLK edges; MOSI bits A5C3 MSB first; done at clk 522; resp=16'h3C5A.
//  3. NUM_SS=2, ss_sel=1, len=8, cmd=16'h00F1, serf returns 8'h96:
//     -> only SS_n[1] low; 8 edges; MOSI 8'hF1; done at clk 266; resp=16'h0096.
//  4. LSB_FIRST=1, CPOL=0, cmd=16'h0001, serf returns 16'h8000 (LSB first):
//     -> first MOSI bit 1; SCLK idles 0; resp=16'h8000.
//  5. snd pulsed at clk 100 of a transfer, and snd with ss_sel=NUM_SS while idle:
//     -> both ignored; first transfer's resp and timing unchanged.
//  6. rst_n low at clk 300 of a transfer -> SS_n all 1 and SCLK idle at once;
//     after release, a new transfer completes normally with the correct resp.

Source files
------------

// File: rtl/spi_mnrch_cfg.sv
// spi_mnrch_cfg: parametrised SPI monarch for the inertial-sensor interface.
// Sits between the sensor/command FSMs and the off-chip SPI serfs.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   snd         1-clk request to start a transaction
//   cmd         word to transmit (right-justified, len_eff bits used)
//   len         bits to transfer; 0 or >DATA_W means DATA_W
//   ss_sel      serf select index; out-of-range requests are dropped
//   MISO        serf -> monarch data
//   SCLK        serial clock, idles at CPOL
//   MOSI        monarch -> serf data
//   SS_n        active-low serf selects
//   resp        received word, right-justified, zero-extended
//   busy        high while a transaction is in flight
//   done        set at completion, held until the next accepted snd
module spi_mnrch_cfg #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned DIV_W     = 5,
   parameter int unsigned NUM_SS    = 1,
   parameter bit          CPOL      = 1'b1,
   parameter bit          LSB_FIRST = 1'b0,
   localparam int unsigned LEN_W    = $clog2(DATA_W + 1),
   localparam int unsigned SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              snd,
   input  logic [DATA_W-1:0] cmd,
   input  logic [LEN_W-1:0]  len,
   input  logic [SEL_W-1:0]  ss_sel,
   input  logic              MISO,
   output logic              SCLK,
   output logic              MOSI,
   output logic [NUM_SS-1:0] SS_n,
   output logic [DATA_W-1:0] resp,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] XFER       = 2'd1;
   localparam logic [1:0] BACK_PORCH = 2'd2;

   // Idle preload puts the first leading SCLK edge P/4+1 clk after the request.
   localparam logic [DIV_W-1:0]  LOAD    = DIV_W'((3 * (1 << DIV_W)) / 4 - 1);
   // Shift two clk after the sampling edge, so MOSI moves well clear of it.
   localparam logic [DIV_W-1:0]  SHFT_AT = DIV_W'((1 << DIV_W) / 2 + 1);
   localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(DATA_W);
   localparam logic [DATA_W-1:0] ONES    = '1;

   logic [1:0]        state;
   logic [DIV_W-1:0]  cnt;
   logic [DATA_W-1:0] sreg;
   logic [LEN_W-1:0]  bcnt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_eff;
   logic [DATA_W-1:0] load_val;
   logic [DATA_W-1:0] shift_val;
   logic [DATA_W-1:0] rx_word;
   logic              init;
   logic              shft;
   logic              last_bit;
   logic              set_done;

   always_comb begin
      len_eff = len;
      if (len == '0 || len > LEN_MAX)
         len_eff = LEN_MAX;
   end

   assign init     = (state == IDLE) && snd && (32'(ss_sel) < NUM_SS);
   assign shft     = (state == XFER) && (cnt == SHFT_AT);
   assign last_bit = (bcnt == len_q - 1'b1);
   assign set_done = (state == BACK_PORCH) && (&cnt);

   always_comb begin
      if (LSB_FIRST) begin
         load_val  = cmd;
         shift_val = {MISO, sreg[DATA_W-1:1]};
         rx_word   = sreg >> (LEN_MAX - len_q);
      end else begin
         load_val  = cmd << (LEN_MAX - len_eff);
         shift_val = {sreg[DATA_W-2:0], MISO};
         rx_word   = sreg & (ONES >> (LEN_MAX - len_q));
      end
   end

   assign SCLK = CPOL ? cnt[DIV_W-1] : ~cnt[DIV_W-1];
   assign MOSI = LSB_FIRST ? sreg[0] : sreg[DATA_W-1];
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= LOAD;
         sreg  <= '0;
         bcnt  <= '0;
         len_q <= '0;
         SS_n  <= '1;
         resp  <= '0;
         done  <= 1'b0;
      end else begin
         // Reload on the completing clk as well, so SCLK never glitches
         // through the wrapped count on its way back to idle.
         if (state == IDLE || set_done)
            cnt <= LOAD;
         else
            cnt <= cnt + 1'b1;

         case (state)
            IDLE: begin
               if (init) begin
                  state <= XFER;
                  sreg  <= load_val;
                  bcnt  <= '0;
                  len_q <= len_eff;
                  done  <= 1'b0;
                  SS_n  <= ~(NUM_SS'(1) << ss_sel);
               end
            end
            XFER: begin
               if (shft) begin
                  sreg <= shift_val;
                  bcnt <= bcnt + 1'b1;
                  if (last_bit)
                     state <= BACK_PORCH;
               end
            end
            BACK_PORCH: begin
               if (set_done) begin
                  state <= IDLE;
                  done  <= 1'b1;
                  SS_n  <= '1;
                  resp  <= rx_word;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mnrch_cfg.sv
`timescale 1ns/1ps
module tb_spi_mnrch_cfg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        snd_a, snd_b, snd_c;
   logic [15:0] cmd;
   logic [4:0]  len;
   logic        sel;
   logic        clr;

   logic        miso_a, sclk_a, mosi_a, busy_a, done_a;
   logic [0:0]  ssn_a;
   logic [15:0] resp_a;
   logic        miso_b, sclk_b, mosi_b, busy_b, done_b;
   logic [1:0]  ssn_b;
   logic [15:0] resp_b;
   logic        miso_c, sclk_c, mosi_c, busy_c, done_c;
   logic [0:0]  ssn_c;
   logic [15:0] resp_c;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_mnrch_cfg u_dut_a (
      .clk(clk), .rst_n(rst_n), .snd(snd_a), .cmd(cmd), .len(len), .ss_sel(sel),
      .MISO(miso_a), .SCLK(sclk_a), .MOSI(mosi_a), .SS_n(ssn_a),
      .resp(resp_a), .busy(busy_a), .done(done_a)
   );

   spi_mnrch_cfg #(.NUM_SS(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .snd(snd_b), .cmd(cmd), .len(len), .ss_sel(sel),
      .MISO(miso_b), .SCLK(sclk_b), .MOSI(mosi_b), .SS_n(ssn_b),
      .resp(resp_b), .busy(busy_b), .done(done_b)
   );

   spi_mnrch_cfg #(.CPOL(1'b0), .LSB_FIRST(1'b1)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .snd(snd_c), .cmd(cmd), .len(len), .ss_sel(sel),
      .MISO(miso_c), .SCLK(sclk_c), .MOSI(mosi_c), .SS_n(ssn_c),
      .resp(resp_c), .busy(busy_c), .done(done_c)
   );

   // Serf models: launch on the leading SCLK edge, sample MOSI on the trailing one.
   // word_* is pre-aligned so the first bit to send sits at the outgoing end.
   logic [15:0] word_a, sh_a, cap_a;
   logic [15:0] word_b, sh_b, cap_b;
   logic [15:0] word_c, sh_c, cap_c;
   int          edges_a, edges_b, edges_c;

   always @(sclk_a, clr) begin
      if (clr) begin
         edges_a = 0; cap_a = '0; sh_a = word_a; miso_a = 1'b0;
      end else if (ssn_a[0] == 1'b0) begin
         if (!sclk_a) begin miso_a = sh_a[15]; sh_a = sh_a << 1; end
         else begin edges_a = edges_a + 1; cap_a = {cap_a[14:0], mosi_a}; end
      end
   end

   always @(sclk_b, clr) begin
      if (clr) begin
         edges_b = 0; cap_b = '0; sh_b = word_b; miso_b = 1'b0;
      end else if (ssn_b[1] == 1'b0) begin
         if (!sclk_b) begin miso_b = sh_b[15]; sh_b = sh_b << 1; end
         else begin edges_b = edges_b + 1; cap_b = {cap_b[14:0], mosi_b}; end
      end
   end

   always @(sclk_c, clr) begin
      if (clr) begin
         edges_c = 0; cap_c = '0; sh_c = word_c; miso_c = 1'b0;
      end else if (ssn_c[0] == 1'b0) begin
         if (sclk_c) begin miso_c = sh_c[0]; sh_c = sh_c >> 1; end
         else begin edges_c = edges_c + 1; cap_c = {mosi_c, cap_c[15:1]}; end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_snd(input int w, input logic v);
      case (w)
         0: snd_a = v;
         1: snd_b = v;
         default: snd_c = v;
      endcase
   endtask

   function automatic logic cur_done(input int w);
      case (w)
         0: return done_a;
         1: return done_b;
         default: return done_c;
      endcase
   endfunction

   function automatic logic cur_busy(input int w);
      case (w)
         0: return busy_a;
         1: return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic logic [1:0] cur_ssn(input int w);
      case (w)
         0: return {1'b0, ssn_a};
         1: return ssn_b;
         default: return {1'b0, ssn_c};
      endcase
   endfunction

   // Called #1 after a posedge. n = clk edges from the snd-sampling edge (1) to done.
   task automatic xfer(input int w, input logic [15:0] c, input logic [4:0] l,
                       input logic s, input int poke_at, input logic [1:0] ss_mid,
                       output int n);
      clr = 1'b1;
      #1 clr = 1'b0;
      cmd = c; len = l; sel = s;
      set_snd(w, 1'b1);
      @(posedge clk); #1;
      set_snd(w, 1'b0);
      n = 1;
      while (!cur_done(w) && n < 2000) begin
         if (n == poke_at) begin cmd = ~c; set_snd(w, 1'b1); end
         else begin cmd = c; set_snd(w, 1'b0); end
         if (n == 200) begin
            chk("busy_mid", {31'd0, cur_busy(w)}, 32'd1);
            chk("ssn_mid", {30'd0, cur_ssn(w)}, {30'd0, ss_mid});
         end
         @(posedge clk); #1;
         n = n + 1;
      end
      set_snd(w, 1'b0);
      cmd = c;
   endtask

   int n;

   initial begin
      rst_n = 1'b0; clr = 1'b0;
      snd_a = 1'b0; snd_b = 1'b0; snd_c = 1'b0;
      cmd = '0; len = '0; sel = 1'b0;
      word_a = '0; word_b = '0; word_c = '0;
      repeat (3) @(posedge clk);
      #1;
      // 1. reset state
      chk("rst_ssn_a", ssn_a, 1);
      chk("rst_ssn_b", ssn_b, 2'b11);
      chk("rst_sclk_a", sclk_a, 1);
      chk("rst_sclk_c", sclk_c, 0);
      chk("rst_mosi_a", mosi_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_resp_a", resp_a, 16'h0000);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2. defaults, full 16-bit transfer
      word_a = 16'h3C5A;
      xfer(0, 16'hA5C3, 5'd0, 1'b0, -1, 2'b00, n);
      chk("t2_latency", n, 522);
      chk("t2_edges", edges_a, 16);
      chk("t2_mosi", cap_a, 16'hA5C3);
      chk("t2_resp", resp_a, 16'h3C5A);
      chk("t2_ssn", ssn_a, 1);
      chk("t2_busy", busy_a, 0);
      chk("t2_done", done_a, 1);

      // 5a. back-to-back request, plus a snd poke mid-transfer
      word_a = 16'h3C5A;
      xfer(0, 16'hA5C3, 5'd0, 1'b0, 100, 2'b00, n);
      chk("t5_latency", n, 522);
      chk("t5_edges", edges_a, 16);
      chk("t5_mosi", cap_a, 16'hA5C3);
      chk("t5_resp", resp_a, 16'h3C5A);

      // 5b. out-of-range serf select while idle
      sel = 1'b1; cmd = 16'h1111; snd_a = 1'b1;
      @(posedge clk); #1;
      snd_a = 1'b0; sel = 1'b0;
      @(posedge clk); #1;
      chk("t5_badsel_busy", busy_a, 0);
      chk("t5_badsel_done", done_a, 1);
      chk("t5_badsel_resp", resp_a, 16'h3C5A);
      chk("t5_badsel_ssn", ssn_a, 1);

      // 3. two selects, 8-bit transfer on serf 1
      word_b = 16'h9600;
      xfer(1, 16'h00F1, 5'd8, 1'b1, -1, 2'b01, n);
      chk("t3_latency", n, 266);
      chk("t3_edges", edges_b, 8);
      chk("t3_mosi", cap_b, 16'h00F1);
      chk("t3_resp", resp_b, 16'h0096);
      chk("t3_ssn", ssn_b, 2'b11);

      // 4. LSB first, CPOL=0
      word_c = 16'h8000;
      xfer(2, 16'h0001, 5'd0, 1'b0, -1, 2'b00, n);
      chk("t4_latency", n, 522);
      chk("t4_edges", edges_c, 16);
      chk("t4_mosi", cap_c, 16'h0001);
      chk("t4_resp", resp_c, 16'h8000);
      chk("t4_sclk_idle", sclk_c, 0);

      // 6. asynchronous abort at clk 300, then a clean transfer
      word_a = 16'hFFFF;
      clr = 1'b1;
      #1 clr = 1'b0;
      cmd = 16'h5555; len = 5'd0; sel = 1'b0; snd_a = 1'b1;
      @(posedge clk); #1;
      snd_a = 1'b0;
      repeat (299) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_ssn", ssn_a, 1);
      chk("t6_sclk", sclk_a, 1);
      chk("t6_busy", busy_a, 0);
      chk("t6_resp", resp_a, 16'h0000);
      chk("t6_done", done_a, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      word_a = 16'hBEEF;
      xfer(0, 16'h1234, 5'd0, 1'b0, -1, 2'b00, n);
      chk("t6_latency", n, 522);
      chk("t6_mosi", cap_a, 16'h1234);
      chk("t6_resp", resp_a, 16'hBEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
